// File: rtl/posit_dot_sequencer_if.sv
// Bundle of handshake and MAC-facing signals between the dot-product sequencer and its environment.
// The sequencer uses the slave view; the driver/MAC side uses the master view.
interface posit_dot_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             issue_en;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;

    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic [7:0]       mac_c;
    logic [7:0]       mac_res;

    logic             busy;
    logic [LEN_W-1:0] done_cnt;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_nar;

    modport master (
        output start, vec_len, issue_en, in_valid, in_a, in_b, mac_res, out_ready,
        input  in_ready, mac_a, mac_b, mac_c, busy, done_cnt, out_valid, out_data, out_nar
    );

    modport slave (
        input  start, vec_len, issue_en, in_valid, in_a, in_b, mac_res, out_ready,
        output in_ready, mac_a, mac_b, mac_c, busy, done_cnt, out_valid, out_data, out_nar
    );
endinterface

// File: rtl/posit_dot_sequencer.sv
// Operand FIFO, issue control and accumulator for an external combinational 8-bit posit MAC.
// Streams a programmed number of A/B pairs through the MAC and returns the dot product on a valid/ready port.
module posit_dot_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    posit_dot_sequencer_if.slave bus
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [7:0]       mem_a [DEPTH];
    logic [7:0]       mem_b [DEPTH];
    logic [DEPTH-1:0] slot_we;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [7:0]       acc_reg;
    logic [LEN_W-1:0] done_reg;
    logic [LEN_W-1:0] accepted_reg;
    logic [LEN_W-1:0] length_reg;

    logic             full;
    logic             empty;
    logic             space_left;
    logic             in_ready;
    logic             issue;
    logic             push;
    logic             out_valid;
    logic             busy;
    logic             start_accept;

    assign full         = (count_reg == FULL_CNT);
    assign empty        = (count_reg == '0);
    assign space_left   = (accepted_reg < length_reg);
    assign push         = in_ready && bus.in_valid;
    assign start_accept = (state_reg == IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // in_ready depends on registered state only, so no path exists from in_valid/issue_en/out_ready.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        issue      = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_next = (bus.vec_len == '0) ? RESULT : RUN;
                end
            end
            RUN: begin
                in_ready = !full && space_left;
                issue    = bus.issue_en && !empty;
                if (issue && ((done_reg + LEN_W'(1)) == length_reg)) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Pair storage carries no reset: occupancy and pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                mem_a[i] <= bus.in_a;
                mem_b[i] <= bus.in_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            acc_reg      <= 8'h00;
            done_reg     <= '0;
            accepted_reg <= '0;
            length_reg   <= '0;
        end else if (start_accept) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            acc_reg      <= 8'h00;
            done_reg     <= '0;
            accepted_reg <= '0;
            length_reg   <= bus.vec_len;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                accepted_reg <= accepted_reg + LEN_W'(1);
            end
            if (issue) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                acc_reg    <= bus.mac_res;
                done_reg   <= done_reg + LEN_W'(1);
            end
            if (push && !issue) begin
                count_reg <= count_reg + (PTR_W + 1)'(1);
            end else if (!push && issue) begin
                count_reg <= count_reg - (PTR_W + 1)'(1);
            end
        end
    end

    // Idle MAC slots see 0*0+acc, so the MAC output never disturbs the held sum.
    assign bus.mac_a     = issue ? mem_a[rd_ptr_reg] : 8'h00;
    assign bus.mac_b     = issue ? mem_b[rd_ptr_reg] : 8'h00;
    assign bus.mac_c     = acc_reg;
    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.done_cnt  = done_reg;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? acc_reg : 8'h00;
    assign bus.out_nar   = out_valid && (acc_reg == 8'h80);
endmodule

// File: doc/posit_dot_sequencer.md
Name: posit_dot_sequencer

Overview:
- Operand-streaming front end that feeds the 8-bit posit (es=0) MAC datapath. Connects to an external combinational `posit_mac_8bit` instance.
- Buffers incoming A/B posit pairs in a small FIFO and issues one pair per enabled cycle to the MAC.
- Owns the accumulator register driven onto the MAC's C input.
- Counts a programmed vector length and presents the final dot product on a valid/ready output port.

Parameters:
- DEPTH, 4, operand FIFO depth in pairs; power of two, ≥2.
- LEN_W, 8, width of the vector-length and progress counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dot product; sampled only in IDLE.
- vec_len  input  LEN_W  number of pairs in the vector; captured on accepted start.
- issue_en  input  1  MAC slot grant; when low, no FIFO pop and no accumulate this cycle.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  operand pair accepted when in_valid & in_ready.
- in_a  input  8  posit operand A.
- in_b  input  8  posit operand B.
- mac_a  output  8  A to MAC: FIFO head A, or 0x00 when no issue.
- mac_b  output  8  B to MAC: FIFO head B, or 0x00 when no issue.
- mac_c  output  8  accumulator register value.
- mac_res  input  8  MAC result, A*B+C, combinational from mac_a/mac_b/mac_c.
- busy  output  1  high in any state other than IDLE.
- done_cnt  output  LEN_W  pairs accumulated so far in the current vector.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_data  output  8  final accumulated posit.
- out_nar  output  1  out_data == 0x80 (NaR); valid when out_valid.

Behaviour:
- Reset (async assert, sync-safe release) clears the following:
  - state=IDLE; FIFO pointers and occupancy = 0; acc=0x00; done_cnt=0; accepted count=0; captured length=0.
  - out_valid=0, out_data=0x00, out_nar=0, in_ready=0, busy=0.
  - Reset mid-operation discards all buffered pairs and the partial sum.
- States:
  - IDLE:
    - start=1 with vec_len≠0 → RUN; capture the length, clear acc, done_cnt, and accepted count.
    - start=1 with vec_len=0 → RESULT with acc=0x00.
  - RUN:
    - in_ready = !full & (accepted < length). Registered-state function only; no combinational path from in_valid, issue_en, or out_ready.
    - A push writes the pair to the FIFO tail and increments accepted.
    - Issue condition = issue_en & !empty. On issue: mac_a/mac_b = head pair; at the clock edge acc<=mac_res, pop, done_cnt+1.
    - Without an issue: mac_a=mac_b=0x00, acc holds.
    - A push and a pop in the same cycle are both performed; occupancy is unchanged.
    - When the issue that makes done_cnt reach the length occurs → RESULT next cycle.
  - RESULT:
    - out_valid=1; out_data=acc; out_nar=(acc==0x80); in_ready=0.
    - out_data is held stable while out_valid & !out_ready.
    - out_valid & out_ready → IDLE; out_valid=0 the following cycle.
    - start asserted in this state, including the handshake cycle, is ignored.
- Latency:
  - A pair pushed in cycle t is issuable no earlier than t+1.
  - With issue_en held high and in_valid continuous, a length-N vector gives out_valid at cycle start+N+2.
- start in RUN or RESULT is ignored. vec_len changes after capture have no effect.
- Pairs presented after the length is reached are not accepted (in_ready=0).
- NaR in either operand propagates through the MAC. The sequencer does not special-case it; out_nar reflects the final value only.
- done_cnt and the accepted counter never exceed the captured length, so there is no wrap.

Test Plan:
- Basic dot product: vec_len=3, pairs (0x40,0x40),(0x40,0x40),(0x60,0x20), issue_en=1 → out_data=0x68 (3.0), out_nar=0, out_valid at start+5.
- Zero length: vec_len=0 with start → out_valid next cycle, out_data=0x00. No in_ready during the operation.
- FIFO full and stall:
  - vec_len=6, issue_en=0, in_valid=1 → exactly 4 pairs accepted, then in_ready=0 and acc holds 0x00.
  - Raise issue_en → drains and accepts the rest; done_cnt reaches 6.
- Output backpressure: out_ready=0 for 5 cycles → out_valid and out_data stable. A start pulse during the wait is ignored. After the handshake → IDLE, busy=0.
- NaR: vec_len=2, pairs (0x80,0x40),(0x40,0x40) → out_data=0x80, out_nar=1.
- Reset mid-run: assert rst after 2 of 4 pairs are accumulated → all outputs at reset values immediately. A new start with vec_len=1, pair (0x40,0x40), → out_data=0x40 (no residue from the prior run).
